// File: rtl/pong_frame_timer.sv
// Frame-strobe prescaler plus NUM_CH programmable every-N-frames event channels.
// Optional single-frame stepping while paused is compiled in with PONG_FRAME_STEP_EN.
module pong_frame_ch #(
    parameter int PER_W          = 8,
    parameter int DEFAULT_PERIOD = 15
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             fstb,
    input  logic             wr_hit,
    input  logic [PER_W-1:0] wr_period,
    output logic             tick
);
    logic [PER_W-1:0] per_q, per_d;
    logic [PER_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // A write always clears the counter, so it also wins over a same-edge frame strobe.
    always_comb begin
        per_d  = per_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (wr_hit) begin
            per_d = wr_period;
            cnt_d = '0;
        end else if (fstb && per_q != '0) begin
            if (cnt_q == per_q - 1'b1) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            per_q  <= PER_W'(DEFAULT_PERIOD);
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            per_q  <= per_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
endmodule

module pong_frame_timer #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int FPS            = 60,
    parameter int NUM_CH         = 4,
    parameter int PER_W          = 8,
    parameter int DEFAULT_PERIOD = 15,
    localparam int DIV           = CLK_HZ / FPS,
    localparam int PRE_W         = $clog2(DIV),
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              enable,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [PER_W-1:0]  wr_period,
    input  logic              step,
    output logic              frame_tick,
    output logic [NUM_CH-1:0] ch_tick,
    output logic [15:0]       frame_count
);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic             frame_tick_q;
    logic             step_fire;
    logic             fstb;

    always_comb begin
`ifdef PONG_FRAME_STEP_EN
        step_fire = !enable && step;
`else
        step_fire = step & 1'b0;
`endif
        fstb          = (enable && pre_q == '0) || step_fire;
        pre_d         = pre_q;
        frame_count_d = frame_count_q;
        if (fstb) begin
            pre_d         = PRE_MAX;
            frame_count_d = frame_count_q + 16'd1;
        end else if (enable) begin
            pre_d = pre_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            pre_q         <= PRE_MAX;
            frame_count_q <= '0;
            frame_tick_q  <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            frame_count_q <= frame_count_d;
            frame_tick_q  <= fstb;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pong_frame_ch #(
            .PER_W         (PER_W),
            .DEFAULT_PERIOD(DEFAULT_PERIOD)
        ) u_ch (
            .clock    (clock),
            .resetn   (resetn),
            .fstb     (fstb),
            .wr_hit   (wr_en && (wr_ch == CH_W'(c))),
            .wr_period(wr_period),
            .tick     (ch_tick[c])
        );
    end

    assign frame_tick  = frame_tick_q;
    assign frame_count = frame_count_q;
endmodule
